// File: rtl/spi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_pkg : shared frame width, timing defaults and FSM encoding for spi_tx_arbiter
// rev 1.0
// ----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_LEN     = 8;
  localparam int GAP_DEFAULT = 4;
  localparam int TMO_DEFAULT = 64;
  localparam int CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_tx_arbiter_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, search begins just after last_i
// rev 1.0
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [NREQ-1:0] winner_o,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  logic [IDXW-1:0] pos;

  // Walk from the farthest offset down to the nearest so the closest hit wins.
  always_comb begin
    winner_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    pos      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      pos = IDXW'((int'(last_i) + k) % NREQ);
      if (req_i[pos]) begin
        winner_o      = '0;
        winner_o[pos] = 1'b1;
        idx_o         = pos;
        valid_o       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_tx_arbiter : round-robin arbiter sharing one SPI serializer among NREQ requesters
// rev 1.0
// ----------------------------------------------------------------------------
module spi_tx_arbiter #(
  parameter int SPI_LEN = spi_pkg::SPI_LEN,
  parameter int NREQ    = 4,
  parameter int GAP     = spi_pkg::GAP_DEFAULT,
  parameter int TMO     = spi_pkg::TMO_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*SPI_LEN-1:0] req_data,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         err,
  output logic [NREQ-1:0]         grant,
  output logic                    spi_en,
  output logic [SPI_LEN-1:0]      spi_data,
  input  logic                    spi_sync_n
);
  import spi_pkg::*;

  localparam int IDXW = $clog2(NREQ);

  state_t               state_q;
  logic [CNT_W-1:0]     wait_cnt_q;
  logic [3:0]           gap_cnt_q;
  logic [IDXW-1:0]      last_q;
  logic [NREQ-1:0]      grant_q;
  logic [NREQ-1:0]      ack_q;
  logic [NREQ-1:0]      err_q;
  logic                 spi_en_q;
  logic [SPI_LEN-1:0]   spi_data_q;

  logic [NREQ-1:0]      pick_win;
  logic [IDXW-1:0]      pick_idx;
  logic                 pick_valid;
  logic                 wait_expired;
  logic                 gap_done;
  logic [CNT_W-1:0]     wait_cnt_inc;
  logic [SPI_LEN-1:0]   pick_frame;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (pick_win),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // The wait counter reaching TMO-1 means TMO full cycles were spent waiting.
  assign wait_expired = (wait_cnt_q == CNT_W'(TMO - 1));
  assign wait_cnt_inc = (wait_cnt_q >= CNT_W'(TMO)) ? wait_cnt_q : wait_cnt_q + 1'b1;
  assign gap_done     = (gap_cnt_q == 4'(GAP - 1));
  assign pick_frame   = req_data[int'(pick_idx)*SPI_LEN +: SPI_LEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      last_q     <= IDXW'(NREQ - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      spi_en_q   <= 1'b0;
      spi_data_q <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            spi_data_q <= pick_frame;
            grant_q    <= pick_win;
            last_q     <= pick_idx;
            spi_en_q   <= 1'b1;
            state_q    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          spi_en_q   <= 1'b0;
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!spi_sync_n) begin
            wait_cnt_q <= '0;
            state_q    <= ST_WAIT_DONE;
          end else if (wait_expired) begin
            err_q     <= grant_q;
            grant_q   <= '0;
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
          end else begin
            wait_cnt_q <= wait_cnt_inc;
          end
        end
        ST_WAIT_DONE: begin
          if (spi_sync_n) begin
            ack_q     <= grant_q;
            grant_q   <= '0;
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
          end else if (wait_expired) begin
            err_q     <= grant_q;
            grant_q   <= '0;
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
          end else begin
            wait_cnt_q <= wait_cnt_inc;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign grant    = grant_q;
  assign spi_en   = spi_en_q;
  assign spi_data = spi_data_q;

endmodule
`default_nettype wire
